// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the single-bit SPI flash read engine.
package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_CS_WAIT = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CMD     = 3'd2,
      ST_ADDR    = 3'd3,
      ST_DATA    = 3'd4,
      ST_RESP    = 3'd5
   } state_t;

   localparam logic [7:0] CMD_READ_DEF = 8'h03;
   localparam int         CMD_BITS     = 8;
   localparam int         ADDR_BITS    = 24;
   localparam int         DATA_BITS    = 32;
   localparam int         BIT_CNT_W    = 6;
   localparam int         DIV_CNT_W    = 4;

endpackage

// File: rtl/spi_flash_rd_ctrl_if.sv
// Request/response handshake bundle between the fetch path (master) and the flash read engine (slave).
interface spi_flash_rd_ctrl_if;
   import spi_flash_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_BITS-1:0] req_addr;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_BITS-1:0] rsp_data;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock divider: flash_clk half-period of CLK_DIV mclk cycles while en is high.
// rise/fall strobe in the mclk cycle before the edge at which flash_clk toggles.
module spi_clk_gen
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic mclk,
   input  logic h_reset_n,
   input  logic en,
   input  logic clr,
   output logic flash_clk,
   output logic rise,
   output logic fall
);

   localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

   logic [DIV_CNT_W-1:0] div_cnt;
   logic                 edge_due;

   assign edge_due = en && (div_cnt == DIV_LAST);
   assign rise     = edge_due && !flash_clk;
   assign fall     = edge_due && flash_clk;

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         div_cnt   <= '0;
         flash_clk <= 1'b0;
      end else if (!en || clr) begin
         div_cnt   <= '0;
         flash_clk <= 1'b0;
      end else if (edge_due) begin
         div_cnt   <= '0;
         flash_clk <= ~flash_clk;
      end else begin
         div_cnt   <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_flash_rd_ctrl.sv
// SPI flash READ engine: 0x03 + 24-bit address, returns 4 bytes little-endian.
// Latency 128*CLK_DIV+1 mclk from request handshake; one outstanding request, response held until rsp_ready.
module spi_flash_rd_ctrl
   import spi_flash_pkg::*;
#(
   parameter int         CLK_DIV  = 2,
   parameter logic [7:0] CMD_READ = CMD_READ_DEF,
   parameter int         CS_IDLE  = 2
) (
   input  logic               mclk,
   input  logic               h_reset_n,
   spi_flash_rd_ctrl_if.slave bus,
   output logic               flash_csb,
   output logic               flash_clk,
   output logic               flash_io0_oe,
   output logic               flash_io0_do,
   input  logic               flash_io1_di
);

   localparam logic [BIT_CNT_W-1:0] CMD_LAST  = BIT_CNT_W'(CMD_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] ADDR_LAST = BIT_CNT_W'(ADDR_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] DATA_END  = BIT_CNT_W'(DATA_BITS);
   localparam logic [3:0]           IDLE_LAST = 4'(CS_IDLE - 1);

   state_t                 state_q;
   state_t                 state_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [3:0]             idle_cnt;
   logic [31:0]            tx_sr;
   logic [DATA_BITS-1:0]   rx_sr;
   logic [DATA_BITS-1:0]   rsp_data_q;
   logic                   csb_q;
   logic                   oe_q;
   logic                   state_chg;
   logic                   data_done;
   logic                   clk_en;
   logic                   rise;
   logic                   fall;

   assign state_chg = (state_nxt != state_q);
   // One idle mclk after the last falling edge before releasing chip select.
   assign data_done = (state_q == ST_DATA) && (bit_cnt == DATA_END);
   assign clk_en    = (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) && !data_done;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .mclk      (mclk),
      .h_reset_n (h_reset_n),
      .en        (clk_en),
      .clr       (state_chg),
      .flash_clk (flash_clk),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) state_q <= ST_CS_WAIT;
      else            state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_CS_WAIT: if (idle_cnt == IDLE_LAST)         state_nxt = ST_IDLE;
         ST_IDLE:    if (bus.req_valid)                 state_nxt = ST_CMD;
         ST_CMD:     if (fall && bit_cnt == CMD_LAST)   state_nxt = ST_ADDR;
         ST_ADDR:    if (fall && bit_cnt == ADDR_LAST)  state_nxt = ST_DATA;
         ST_DATA:    if (data_done)                     state_nxt = ST_RESP;
         ST_RESP:    if (bus.rsp_ready)                 state_nxt = ST_CS_WAIT;
         default:                                       state_nxt = ST_CS_WAIT;
      endcase
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         bit_cnt    <= '0;
         idle_cnt   <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         rsp_data_q <= '0;
         csb_q      <= 1'b1;
         oe_q       <= 1'b0;
      end else begin
         if (state_chg) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
         end else begin
            if (fall)                   bit_cnt  <= bit_cnt + 1'b1;
            if (state_q == ST_CS_WAIT)  idle_cnt <= idle_cnt + 1'b1;
         end

         if (state_q == ST_IDLE && bus.req_valid)
            tx_sr <= {CMD_READ, bus.req_addr};
         else if (fall && (state_q == ST_CMD || state_q == ST_ADDR))
            tx_sr <= {tx_sr[30:0], 1'b0};

         // Byte k of the stream lands in [8k+7:8k], each byte arriving MSB first.
         if (rise && state_q == ST_DATA)
            rx_sr[{bit_cnt[4:3], ~bit_cnt[2:0]}] <= flash_io1_di;

         if (state_q == ST_DATA && state_nxt == ST_RESP)
            rsp_data_q <= rx_sr;

         csb_q <= !(state_nxt == ST_CMD || state_nxt == ST_ADDR || state_nxt == ST_DATA);
         oe_q  <=  (state_nxt == ST_CMD || state_nxt == ST_ADDR);
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_data  = rsp_data_q;

   assign flash_csb    = csb_q;
   assign flash_io0_oe = oe_q;
   assign flash_io0_do = tx_sr[31];

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: three builds (CLK_DIV 2,1,4) each attached to a behavioural SPI flash.
module tb_spi_flash_rd_ctrl;

   localparam int N       = 3;
   localparam int CS_IDLE = 2;

   logic mclk = 1'b0;
   logic rst_n;
   always #5 mclk = ~mclk;

   logic [N-1:0] req_valid;
   logic [N-1:0] rsp_ready;
   logic [23:0]  req_addr [N];
   wire  [N-1:0] req_ready, rsp_valid, csb, fclk, oe, io0;
   wire  [31:0]  rsp_data [N];
   wire  [31:0]  cap_w    [N];

   logic [7:0] mem [logic [23:0]];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   // Flash contents: preloaded bytes, otherwise a fixed hash of the address.
   function automatic logic [7:0] fb(input logic [23:0] a);
      logic [23:0] h;
      if (mem.exists(a)) return mem[a];
      h = (a * 24'd40503) ^ 24'h5A5A5A;
      return h[15:8] ^ h[7:0];
   endfunction

   function automatic logic [31:0] exp_word(input logic [23:0] a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = fb(a + 24'(k));
      return w;
   endfunction

   for (genvar g = 0; g < N; g++) begin : u
      localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      spi_flash_rd_ctrl_if bus ();
      int          cnt = 0;
      int          idx;
      logic [31:0] cap = '0;
      logic [7:0]  b;
      logic        io1 = 1'b0;

      assign bus.req_valid = req_valid[g];
      assign bus.req_addr  = req_addr[g];
      assign bus.rsp_ready = rsp_ready[g];
      assign req_ready[g]  = bus.req_ready;
      assign rsp_valid[g]  = bus.rsp_valid;
      assign rsp_data[g]   = bus.rsp_data;
      assign cap_w[g]      = cap;

      spi_flash_rd_ctrl #(.CLK_DIV(DIV), .CMD_READ(8'h03), .CS_IDLE(CS_IDLE)) dut (
         .mclk         (mclk),
         .h_reset_n    (rst_n),
         .bus          (bus),
         .flash_csb    (csb[g]),
         .flash_clk    (fclk[g]),
         .flash_io0_oe (oe[g]),
         .flash_io0_do (io0[g]),
         .flash_io1_di (io1)
      );

      // Mode-0 flash: captures command+address on rising edges, shifts data out on falling edges.
      always @(fclk[g] or csb[g]) begin
         if (csb[g]) begin
            cnt = 0;
         end else if (fclk[g]) begin
            if (cnt < 32) cap = {cap[30:0], io0[g]};
            cnt++;
         end else if (cnt >= 32) begin
            idx = cnt - 32;
            b   = fb(cap[23:0] + 24'(idx / 8));
            io1 = b[3'(7 - (idx % 8))];
         end
      end
   end

   int hi_run  = 0;
   int min_gap = 1000000;
   always @(negedge mclk) begin
      if (csb[0]) hi_run++;
      else begin
         if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         hi_run = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_read(input int g, input logic [23:0] a, input int hold,
                          input logic [31:0] exp, input int exp_lat);
      int t, lat, nrise, r1, r2;
      logic pc, stable;
      logic [31:0] d;
      t = 0;
      while (!req_ready[g] && t < 2000) begin @(negedge mclk); t++; end
      check("req_ready_timeout", 32'(t >= 2000), 32'd0);
      req_addr[g]  = a;
      req_valid[g] = 1'b1;
      @(negedge mclk);
      req_valid[g] = 1'b0;
      check("start_pins", 32'({csb[g], oe[g], io0[g], req_ready[g]}), 32'b0100);
      lat = 0; nrise = 0; r1 = -1; r2 = -1; pc = fclk[g];
      while (!rsp_valid[g] && lat < 3000) begin
         @(negedge mclk);
         lat++;
         if (fclk[g] && !pc) begin
            nrise++;
            if (r1 < 0) r1 = lat; else if (r2 < 0) r2 = lat;
         end
         pc = fclk[g];
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("clk_rises", 32'(nrise), 32'd64);
      check("clk_period", 32'(r2 - r1), 32'(2 * div_of(g)));
      check("rsp_data", rsp_data[g], exp);
      check("cmd_addr_seen", cap_w[g], {8'h03, a});
      check("pins_at_rsp", 32'({csb[g], fclk[g], oe[g], req_ready[g]}), 32'b1000);
      stable = 1'b1;
      d = rsp_data[g];
      for (int i = 0; i < hold; i++) begin
         @(negedge mclk);
         if (!rsp_valid[g] || rsp_data[g] !== d || req_ready[g]) stable = 1'b0;
      end
      if (hold > 0) check("rsp_hold_stable", 32'(stable), 32'd1);
      rsp_ready[g] = 1'b1;
      @(negedge mclk);
      rsp_ready[g] = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid[g]), 32'd0);
      t = 1;
      while (!req_ready[g] && t < 100) begin @(negedge mclk); t++; end
      check("ready_gap", 32'(t), 32'(CS_IDLE + 1));
   endtask

   typedef struct {
      int          g;
      logic [23:0] addr;
      int          hold;
      logic [31:0] data;
      int          lat;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int t;
      logic seen;
      logic [23:0] a;
      int g;

      tbl[0] = '{0, 24'h000000,  0, 32'h44332211, 257};
      tbl[1] = '{0, 24'h000102, 20, 32'hD4C3B2A1, 257};
      tbl[2] = '{0, 24'h000010,  0, 32'h04030201, 257};
      tbl[3] = '{0, 24'h000014,  0, 32'h08070605, 257};
      tbl[4] = '{1, 24'h000000,  3, 32'h44332211, 129};
      tbl[5] = '{2, 24'h000010,  0, 32'h04030201, 513};
      tbl[6] = '{0, 24'hFFFFFE,  2, 32'h2211FFEE, 257};
      tbl[7] = '{2, 24'hFFFFFF,  0, 32'h332211FF, 513};

      mem[24'h000000] = 8'h11; mem[24'h000001] = 8'h22;
      mem[24'h000002] = 8'h33; mem[24'h000003] = 8'h44;
      mem[24'h000102] = 8'hA1; mem[24'h000103] = 8'hB2;
      mem[24'h000104] = 8'hC3; mem[24'h000105] = 8'hD4;
      for (int i = 0; i < 8; i++) mem[24'h10 + 24'(i)] = 8'(i + 1);
      mem[24'hFFFFFE] = 8'hEE; mem[24'hFFFFFF] = 8'hFF;

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      for (int i = 0; i < N; i++) req_addr[i] = '0;
      repeat (3) @(negedge mclk);

      for (int i = 0; i < N; i++) begin
         check("reset_pins", 32'({req_ready[i], rsp_valid[i], csb[i], fclk[i], oe[i], io0[i]}), 32'b001000);
         check("reset_rsp_data", rsp_data[i], 32'h0);
      end

      rst_n = 1'b1;
      t = 0;
      while (!req_ready[0] && t < 100) begin @(negedge mclk); t++; end
      check("ready_after_reset", 32'(t), 32'(CS_IDLE));

      for (int i = 0; i < 8; i++)
         do_read(tbl[i].g, tbl[i].addr, tbl[i].hold, tbl[i].data, tbl[i].lat);

      // Reset pulse in the middle of data bit 10 on the CLK_DIV=2 build.
      req_addr[0]  = 24'h000020;
      req_valid[0] = 1'b1;
      @(negedge mclk);
      req_valid[0] = 1'b0;
      repeat (169) @(negedge mclk);
      check("mid_reset_in_data", 32'({csb[0], oe[0]}), 32'b00);
      rst_n = 1'b0;
      #1;
      check("mid_reset_pins", 32'({csb[0], fclk[0], oe[0], io0[0], rsp_valid[0], req_ready[0]}), 32'b100000);
      check("mid_reset_rsp_data", rsp_data[0], 32'h0);
      repeat (2) @(negedge mclk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge mclk);
         if (rsp_valid[0]) seen = 1'b1;
      end
      check("no_rsp_after_reset", 32'(seen), 32'd0);
      do_read(0, 24'h000020, 0, exp_word(24'h000020), 257);

      for (int i = 0; i < 30; i++) begin
         g = int'($urandom_range(0, 2));
         a = 24'($urandom);
         if (i % 7 == 0) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
         do_read(g, a, int'($urandom_range(0, 4)), exp_word(a), 128 * div_of(g) + 1);
      end

      check("csb_min_gap", 32'(min_gap >= CS_IDLE), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
